// File: rtl/kbd_source_arbiter.sv
// Two-source (PS/2, UART) arbiter feeding the Apple-1 keyboard register, with a read hold-off gap.
// Optional build macro KBD_UPCASE_EN folds lower-case ASCII to upper case at capture.
module kbd_source_arbiter #(
  parameter int HOLDOFF = 64,
  parameter int CNT_W   = 8
) (
  input  logic       clk25,
  input  logic       reset,
  input  logic       ps2_en,
  input  logic       uart_en,
  input  logic       ps2_valid,
  input  logic [7:0] ps2_data,
  input  logic       uart_valid,
  input  logic [7:0] uart_data,
  input  logic       kbd_read,
  input  logic       ovf_clr,
  output logic [6:0] kbd_data,
  output logic       kbd_ready,
  output logic       kbd_src,
  output logic       ps2_ovf,
  output logic       uart_ovf
);

  typedef enum logic [1:0] {ST_IDLE, ST_FULL, ST_HOLDOFF} state_t;

  localparam logic [CNT_W-1:0] CNT_INIT = HOLDOFF[CNT_W-1:0];
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  function automatic logic [6:0] fold_case(input logic [6:0] c);
`ifdef KBD_UPCASE_EN
    if (c >= 7'h61 && c <= 7'h7A) return c - 7'h20;
`endif
    return c;
  endfunction

  logic [1:0] en_w;
  logic [1:0] valid_w;
  logic [6:0] data_w [2];
  logic [1:0] pend_w;
  logic [6:0] hold_w [2];
  logic [1:0] ovf_w;
  logic [1:0] grant_w;
  logic [1:0] avail_w;
  logic       sel_w;
  logic       unused_bit7;

  assign en_w        = {uart_en, ps2_en};
  assign valid_w     = {uart_valid, ps2_valid};
  assign data_w[0]   = ps2_data[6:0];
  assign data_w[1]   = uart_data[6:0];
  assign unused_bit7 = ^{ps2_data[7], uart_data[7]};

  // One holding register per source; index 0 = PS/2, 1 = UART.
  for (genvar gi = 0; gi < 2; gi++) begin : g_src
    logic       pend_reg;
    logic [6:0] hold_reg;
    logic       ovf_reg;
    logic       drop_w;

    // A new character is dropped only if the slot is full and not being emptied this cycle.
    assign drop_w = en_w[gi] && valid_w[gi] && pend_reg && !grant_w[gi];

    always_ff @(posedge clk25 or posedge reset) begin
      if (reset) begin
        pend_reg <= 1'b0;
        hold_reg <= '0;
        ovf_reg  <= 1'b0;
      end else begin
        if (!en_w[gi]) begin
          pend_reg <= 1'b0;
        end else if (valid_w[gi]) begin
          if (!pend_reg || grant_w[gi]) begin
            hold_reg <= fold_case(data_w[gi]);
            pend_reg <= 1'b1;
          end
        end else if (grant_w[gi]) begin
          pend_reg <= 1'b0;
        end

        if (drop_w)       ovf_reg <= 1'b1;
        else if (ovf_clr) ovf_reg <= 1'b0;
      end
    end

    assign pend_w[gi] = pend_reg;
    assign hold_w[gi] = hold_reg;
    assign ovf_w[gi]  = ovf_reg;
  end

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             rr_reg, rr_next;
  logic [6:0]       kbd_data_reg, kbd_data_next;
  logic             kbd_src_reg, kbd_src_next;
  logic             kbd_ready_reg, kbd_ready_next;

  // rr_reg names the source preferred when both are waiting.
  assign avail_w = pend_w & en_w;
  assign sel_w   = (avail_w == 2'b11) ? rr_reg : avail_w[1];

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    rr_next        = rr_reg;
    kbd_data_next  = kbd_data_reg;
    kbd_src_next   = kbd_src_reg;
    kbd_ready_next = kbd_ready_reg;
    grant_w        = 2'b00;
    case (state_reg)
      ST_IDLE: begin
        kbd_ready_next = 1'b0;
        if (avail_w != 2'b00) begin
          grant_w        = sel_w ? 2'b10 : 2'b01;
          kbd_data_next  = hold_w[sel_w];
          kbd_src_next   = sel_w;
          kbd_ready_next = 1'b1;
          rr_next        = ~sel_w;
          state_next     = ST_FULL;
        end
      end
      ST_FULL: begin
        if (kbd_read) begin
          kbd_ready_next = 1'b0;
          if (HOLDOFF == 0) begin
            state_next = ST_IDLE;
          end else begin
            cnt_next   = CNT_INIT;
            state_next = ST_HOLDOFF;
          end
        end
      end
      ST_HOLDOFF: begin
        kbd_ready_next = 1'b0;
        if (cnt_reg <= CNT_ONE) begin
          cnt_next   = '0;
          state_next = ST_IDLE;
        end else begin
          cnt_next = cnt_reg - CNT_ONE;
        end
      end
      default: begin
        kbd_ready_next = 1'b0;
        state_next     = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk25 or posedge reset) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      cnt_reg       <= '0;
      rr_reg        <= 1'b0;
      kbd_data_reg  <= '0;
      kbd_src_reg   <= 1'b0;
      kbd_ready_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      rr_reg        <= rr_next;
      kbd_data_reg  <= kbd_data_next;
      kbd_src_reg   <= kbd_src_next;
      kbd_ready_reg <= kbd_ready_next;
    end
  end

  assign kbd_data  = kbd_data_reg;
  assign kbd_src   = kbd_src_reg;
  assign kbd_ready = kbd_ready_reg;
  assign ps2_ovf   = ovf_w[0];
  assign uart_ovf  = ovf_w[1];

endmodule

// File: tb/tb_kbd_source_arbiter.sv
// Self-checking bench for kbd_source_arbiter: directed scenarios plus random traffic vs a cycle model.
module tb_kbd_source_arbiter;

  localparam int HOLDOFF = 64;

  logic       clk25 = 1'b0;
  logic       reset = 1'b1;
  logic       ps2_en = 1'b0, uart_en = 1'b0;
  logic       ps2_valid = 1'b0, uart_valid = 1'b0;
  logic [7:0] ps2_data = 8'h00, uart_data = 8'h00;
  logic       kbd_read = 1'b0, ovf_clr = 1'b0;
  logic [6:0] kbd_data;
  logic       kbd_ready, kbd_src, ps2_ovf, uart_ovf;

  int errors = 0;
  int checks = 0;

  kbd_source_arbiter #(.HOLDOFF(HOLDOFF), .CNT_W(8)) dut (
    .clk25(clk25), .reset(reset), .ps2_en(ps2_en), .uart_en(uart_en),
    .ps2_valid(ps2_valid), .ps2_data(ps2_data), .uart_valid(uart_valid), .uart_data(uart_data),
    .kbd_read(kbd_read), .ovf_clr(ovf_clr), .kbd_data(kbd_data), .kbd_ready(kbd_ready),
    .kbd_src(kbd_src), .ps2_ovf(ps2_ovf), .uart_ovf(uart_ovf)
  );

  always #5 clk25 = ~clk25;

  // Reference model: gap counts edges to wait before another grant is allowed.
  typedef struct packed {
    logic [1:0]      pend;
    logic [1:0][6:0] hold;
    logic [1:0]      ovf;
    logic            ready;
    logic [6:0]      data;
    logic            src;
    logic            last;
    int              gap;
  } model_t;

  localparam model_t MODEL_RESET = '{pend: 2'b00, hold: '0, ovf: 2'b00, ready: 1'b0,
                                     data: 7'h00, src: 1'b0, last: 1'b1, gap: 0};
  model_t m = MODEL_RESET;

  function automatic logic [6:0] upc(input logic [6:0] c);
`ifdef KBD_UPCASE_EN
    if (c >= 7'h61 && c <= 7'h7A) return c - 7'h20;
`endif
    return c;
  endfunction

  function automatic model_t model_next(input model_t s);
    model_t n;
    logic [1:0] en, v, avail, drop;
    logic [1:0][6:0] d;
    int g;
    n = s;
    en = {uart_en, ps2_en};
    v = {uart_valid, ps2_valid};
    d[0] = upc(ps2_data[6:0]);
    d[1] = upc(uart_data[6:0]);
    avail = s.pend & en;
    drop = 2'b00;
    g = -1;
    if (s.ready) begin
      if (kbd_read) begin n.ready = 1'b0; n.gap = HOLDOFF; end
    end else if (s.gap > 0) n.gap = s.gap - 1;
    else if (avail == 2'b11) g = s.last ? 0 : 1;
    else if (avail[0]) g = 0;
    else if (avail[1]) g = 1;
    if (g >= 0) begin
      n.ready = 1'b1;
      n.data = s.hold[g];
      n.src = (g == 1);
      n.last = (g == 1);
    end
    for (int i = 0; i < 2; i++) begin
      if (!en[i]) n.pend[i] = 1'b0;
      else if (v[i]) begin
        if (!s.pend[i] || g == i) begin n.hold[i] = d[i]; n.pend[i] = 1'b1; end
        else drop[i] = 1'b1;
      end else if (g == i) n.pend[i] = 1'b0;
      n.ovf[i] = drop[i] ? 1'b1 : (ovf_clr ? 1'b0 : s.ovf[i]);
    end
    return n;
  endfunction

  always @(posedge clk25 or posedge reset) begin
    if (reset) m <= MODEL_RESET;
    else       m <= model_next(m);
  end

  task automatic tick();
    @(posedge clk25);
    #1;
  endtask

  task automatic send_ps2(input logic [7:0] c);
    ps2_data = c; ps2_valid = 1'b1; tick(); ps2_valid = 1'b0;
  endtask

  task automatic send_uart(input logic [7:0] c);
    uart_data = c; uart_valid = 1'b1; tick(); uart_valid = 1'b0;
  endtask

  task automatic pulse_read();
    kbd_read = 1'b1; tick(); kbd_read = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1; tick(); tick(); reset = 1'b0;
    ps2_en = 1'b1; uart_en = 1'b1;
  endtask

  task automatic wait_ready(input int max_cycles, output int n);
    n = 0;
    while (!kbd_ready && n < max_cycles) begin n++; tick(); end
  endtask

  task automatic test_reset();
    tick(); tick();
    checks++;
    if ({kbd_ready, kbd_src, kbd_data, ps2_ovf, uart_ovf} !== 11'h0) begin
      errors++;
      $display("FAIL reset_state: got ready=%b src=%b data=%h povf=%b uovf=%b, want all 0",
               kbd_ready, kbd_src, kbd_data, ps2_ovf, uart_ovf);
    end
    $display("test_reset: outputs ready=%b data=%h", kbd_ready, kbd_data);
  endtask

  task automatic test_single();
    do_reset();
    send_ps2(8'h41);
    checks++;
    if (kbd_ready !== 1'b0) begin errors++; $display("FAIL single_latency1: ready=%b want 0", kbd_ready); end
    tick();
    checks++;
    if ({kbd_ready, kbd_src, kbd_data} !== {1'b1, 1'b0, 7'h41}) begin
      errors++; $display("FAIL single_grant: ready=%b src=%b data=%h want 1 0 41", kbd_ready, kbd_src, kbd_data);
    end
    repeat (5) tick();
    checks++;
    if ({kbd_ready, kbd_src, kbd_data} !== {1'b1, 1'b0, 7'h41}) begin
      errors++; $display("FAIL single_hold: ready=%b src=%b data=%h want 1 0 41", kbd_ready, kbd_src, kbd_data);
    end
    pulse_read();
    checks++;
    if (kbd_ready !== 1'b0) begin errors++; $display("FAIL single_read: ready=%b want 0", kbd_ready); end
    $display("test_single: data=%h src=%b", kbd_data, kbd_src);
  endtask

  task automatic test_both_holdoff();
    int n;
    do_reset();
    ps2_data = 8'h31; uart_data = 8'h32; ps2_valid = 1'b1; uart_valid = 1'b1;
    tick();
    ps2_valid = 1'b0; uart_valid = 1'b0;
    tick();
    checks++;
    if ({kbd_ready, kbd_src, kbd_data} !== {1'b1, 1'b0, 7'h31}) begin
      errors++; $display("FAIL both_first: ready=%b src=%b data=%h want 1 0 31", kbd_ready, kbd_src, kbd_data);
    end
    pulse_read();
    wait_ready(300, n);
    checks++;
    if (n !== HOLDOFF + 1) begin errors++; $display("FAIL holdoff_gap: low for %0d cycles want %0d", n, HOLDOFF + 1); end
    checks++;
    if ({kbd_ready, kbd_src, kbd_data} !== {1'b1, 1'b1, 7'h32}) begin
      errors++; $display("FAIL both_second: ready=%b src=%b data=%h want 1 1 32", kbd_ready, kbd_src, kbd_data);
    end
    $display("test_both_holdoff: gap=%0d second=%h src=%b", n, kbd_data, kbd_src);
  endtask

  task automatic test_overflow();
    int n;
    do_reset();
    ps2_valid = 1'b1;
    ps2_data = 8'h41; tick();
    ps2_data = 8'h42; tick();
    ps2_data = 8'h43; tick();
    ps2_valid = 1'b0;
    checks++;
    if ({kbd_ready, kbd_data, ps2_ovf, uart_ovf} !== {1'b1, 7'h41, 1'b1, 1'b0}) begin
      errors++; $display("FAIL ovf_set: ready=%b data=%h povf=%b uovf=%b want 1 41 1 0", kbd_ready, kbd_data, ps2_ovf, uart_ovf);
    end
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    checks++;
    if (ps2_ovf !== 1'b0) begin errors++; $display("FAIL ovf_clr: povf=%b want 0", ps2_ovf); end
    pulse_read();
    wait_ready(300, n);
    checks++;
    if ({kbd_ready, kbd_src, kbd_data} !== {1'b1, 1'b0, 7'h42}) begin
      errors++; $display("FAIL ovf_held: ready=%b src=%b data=%h want 1 0 42", kbd_ready, kbd_src, kbd_data);
    end
    pulse_read();
    wait_ready(150, n);
    checks++;
    if (kbd_ready !== 1'b0) begin errors++; $display("FAIL ovf_dropped: ready=%b data=%h want no third char", kbd_ready, kbd_data); end
    // Drop in the same cycle as ovf_clr: the flag must still end up set.
    ps2_valid = 1'b1;
    ps2_data = 8'h44; tick();
    ps2_data = 8'h45; tick();
    ps2_data = 8'h46; ovf_clr = 1'b1; tick();
    ps2_valid = 1'b0; ovf_clr = 1'b0;
    checks++;
    if (ps2_ovf !== 1'b1) begin errors++; $display("FAIL ovf_set_wins: povf=%b want 1", ps2_ovf); end
    $display("test_overflow: povf=%b data=%h", ps2_ovf, kbd_data);
  endtask

  task automatic test_disable();
    do_reset();
    ps2_en = 1'b0;
    send_ps2(8'h41);
    repeat (3) tick();
    checks++;
    if ({kbd_ready, ps2_ovf} !== 2'b00) begin errors++; $display("FAIL disable_ignore: ready=%b povf=%b want 0 0", kbd_ready, ps2_ovf); end
    send_uart(8'h0D);
    tick();
    checks++;
    if ({kbd_ready, kbd_src, kbd_data} !== {1'b1, 1'b1, 7'h0D}) begin
      errors++; $display("FAIL disable_uart: ready=%b src=%b data=%h want 1 1 0d", kbd_ready, kbd_src, kbd_data);
    end
    ps2_en = 1'b1;
    $display("test_disable: data=%h src=%b", kbd_data, kbd_src);
  endtask

  task automatic test_reset_mid();
    do_reset();
    send_ps2(8'h41); send_ps2(8'h42); send_ps2(8'h43);
    #3 reset = 1'b1;
    #1;
    checks++;
    if ({kbd_ready, kbd_src, kbd_data, ps2_ovf, uart_ovf} !== 11'h0) begin
      errors++; $display("FAIL reset_in_full: ready=%b src=%b data=%h povf=%b want all 0", kbd_ready, kbd_src, kbd_data, ps2_ovf);
    end
    tick(); reset = 1'b0;
    send_uart(8'h52); tick();
    pulse_read();
    repeat (3) tick();
    #3 reset = 1'b1;
    #1;
    checks++;
    if ({kbd_ready, kbd_src, kbd_data} !== 9'h0) begin
      errors++; $display("FAIL reset_in_holdoff: ready=%b src=%b data=%h want all 0", kbd_ready, kbd_src, kbd_data);
    end
    tick(); reset = 1'b0;
    send_uart(8'h45);
    checks++;
    if (kbd_ready !== 1'b0) begin errors++; $display("FAIL post_reset_lat1: ready=%b want 0", kbd_ready); end
    tick();
    checks++;
    if ({kbd_ready, kbd_src, kbd_data} !== {1'b1, 1'b1, 7'h45}) begin
      errors++; $display("FAIL post_reset_char: ready=%b src=%b data=%h want 1 1 45", kbd_ready, kbd_src, kbd_data);
    end
    $display("test_reset_mid: data=%h src=%b", kbd_data, kbd_src);
  endtask

  task automatic test_upcase();
    logic [7:0] codes [5];
    logic [6:0] want  [5];
    codes = '{8'h61, 8'h7A, 8'h7B, 8'h60, 8'hE1};
`ifdef KBD_UPCASE_EN
    want  = '{7'h41, 7'h5A, 7'h7B, 7'h60, 7'h41};
`else
    want  = '{7'h61, 7'h7A, 7'h7B, 7'h60, 7'h61};
`endif
    for (int i = 0; i < 5; i++) begin
      do_reset();
      send_uart(codes[i]);
      tick();
      checks++;
      if ({kbd_ready, kbd_data} !== {1'b1, want[i]}) begin
        errors++; $display("FAIL upcase_%0d: in=%h ready=%b data=%h want 1 %h", i, codes[i], kbd_ready, kbd_data, want[i]);
      end
      $display("test_upcase: in=%h out=%h", codes[i], kbd_data);
    end
  endtask

  task automatic test_random();
    int bad;
    bad = 0;
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      ps2_valid  = ($urandom_range(0, 7) == 0);
      uart_valid = ($urandom_range(0, 7) == 0);
      ps2_data   = 8'($urandom);
      uart_data  = 8'($urandom);
      kbd_read   = ($urandom_range(0, 5) == 0);
      ovf_clr    = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 199) == 0) ps2_en = ~ps2_en;
      if ($urandom_range(0, 199) == 0) uart_en = ~uart_en;
      tick();
      checks++;
      if ({kbd_ready, kbd_src, kbd_data, ps2_ovf, uart_ovf} !== {m.ready, m.src, m.data, m.ovf[0], m.ovf[1]}) begin
        errors++; bad++;
        $display("FAIL random_cycle_%0d: got r=%b s=%b d=%h po=%b uo=%b want r=%b s=%b d=%h po=%b uo=%b", c,
                 kbd_ready, kbd_src, kbd_data, ps2_ovf, uart_ovf, m.ready, m.src, m.data, m.ovf[0], m.ovf[1]);
      end
    end
    ps2_valid = 1'b0; uart_valid = 1'b0; kbd_read = 1'b0; ovf_clr = 1'b0;
    $display("test_random: 4000 cycles, %0d mismatching", bad);
  endtask

  initial begin
    test_reset();
    test_single();
    test_both_holdoff();
    test_overflow();
    test_disable();
    test_reset_mid();
    test_upcase();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
